// File: rtl/phys_reg_ready_table_sched.sv
// Physical-register ready table for dispatch: immediate completes,
// scheduled (countdown) wakeups with cancel, and forwarded lookups.
module phys_reg_ready_table_sched #(
    parameter int NUM_PHYS_REGS  = 64,
    parameter int NUM_ARCH_REGS  = 32,
    parameter int DISPATCH_WIDTH = 2,
    parameter int NUM_COMPLETE   = 3,
    parameter int NUM_WAKEUP     = 2,
    parameter int MAX_LAT        = 4,
    parameter int TAG_W          = $clog2(NUM_PHYS_REGS),
    parameter int LAT_W          = $clog2(MAX_LAT + 1)
) (
    input  logic                                      CLK,
    input  logic                                      nRST,
    output logic                                      DUT_error,
    input  logic [2*DISPATCH_WIDTH-1:0][TAG_W-1:0]    dispatch_source_tag,
    output logic [2*DISPATCH_WIDTH-1:0]               dispatch_source_ready,
    input  logic [DISPATCH_WIDTH-1:0]                 dispatch_dest_write,
    input  logic [DISPATCH_WIDTH-1:0][TAG_W-1:0]      dispatch_dest_tag,
    input  logic [NUM_COMPLETE-1:0]                   complete_valid,
    input  logic [NUM_COMPLETE-1:0][TAG_W-1:0]        complete_tag,
    input  logic [NUM_WAKEUP-1:0]                     wakeup_valid,
    input  logic [NUM_WAKEUP-1:0][TAG_W-1:0]          wakeup_tag,
    input  logic [NUM_WAKEUP-1:0][LAT_W-1:0]          wakeup_latency,
    input  logic                                      cancel_valid,
    input  logic [TAG_W-1:0]                          cancel_tag
);

    localparam int NW = DISPATCH_WIDTH + NUM_COMPLETE + NUM_WAKEUP;

    function automatic logic [NUM_PHYS_REGS-1:0] reset_rdy();
        logic [NUM_PHYS_REGS-1:0] v;
        for (int i = 0; i < NUM_PHYS_REGS; i++) begin
            v[i] = (i < NUM_ARCH_REGS);
        end
        v[0] = 1'b1;
        return v;
    endfunction

    localparam logic [NUM_PHYS_REGS-1:0] RST_RDY = reset_rdy();

    logic [NUM_PHYS_REGS-1:0]             rdy_q, rdy_d;
    logic [NUM_PHYS_REGS-1:0][LAT_W-1:0]  cnt_q, cnt_d;
    logic [NUM_PHYS_REGS-1:0]             cmp_hit;
    logic                                 err_q, err_d, col_err;
    logic [NW-1:0]                        w_vld;
    logic [NW-1:0][TAG_W-1:0]             w_tag;

    // Gather every writer so same-tag collisions can be detected.
    always_comb begin
        w_vld   = '0;
        w_tag   = '0;
        col_err = 1'b0;
        for (int w = 0; w < DISPATCH_WIDTH; w++) begin
            w_vld[w] = dispatch_dest_write[w];
            w_tag[w] = dispatch_dest_tag[w];
        end
        for (int c = 0; c < NUM_COMPLETE; c++) begin
            w_vld[DISPATCH_WIDTH+c] = complete_valid[c];
            w_tag[DISPATCH_WIDTH+c] = complete_tag[c];
        end
        for (int k = 0; k < NUM_WAKEUP; k++) begin
            w_vld[DISPATCH_WIDTH+NUM_COMPLETE+k] = wakeup_valid[k];
            w_tag[DISPATCH_WIDTH+NUM_COMPLETE+k] = wakeup_tag[k];
        end
        for (int a = 0; a < NW; a++) begin
            for (int b = a + 1; b < NW; b++) begin
                if (w_vld[a] && w_vld[b] && (w_tag[a] == w_tag[b])) begin
                    col_err = 1'b1;
                end
            end
        end
    end

    // Next-state: countdown, clear, complete, wakeup, cancel (later wins).
    always_comb begin
        rdy_d   = rdy_q;
        cnt_d   = cnt_q;
        cmp_hit = '0;
        err_d   = 1'b0;
        for (int e = 0; e < NUM_PHYS_REGS; e++) begin
            if (cnt_q[e] != '0) begin
                cnt_d[e] = cnt_q[e] - LAT_W'(1);
                if (cnt_q[e] == LAT_W'(1)) begin
                    rdy_d[e] = 1'b1;
                end
            end
        end
        for (int w = 0; w < DISPATCH_WIDTH; w++) begin
            if (dispatch_dest_write[w]) begin
                if (dispatch_dest_tag[w] == '0) begin
                    err_d = 1'b1;
                end else begin
                    rdy_d[dispatch_dest_tag[w]] = 1'b0;
                    cnt_d[dispatch_dest_tag[w]] = '0;
                end
            end
        end
        for (int c = 0; c < NUM_COMPLETE; c++) begin
            if (complete_valid[c]) begin
                if (complete_tag[c] == '0) begin
                    err_d = 1'b1;
                end else begin
                    rdy_d[complete_tag[c]]   = 1'b1;
                    cnt_d[complete_tag[c]]   = '0;
                    cmp_hit[complete_tag[c]] = 1'b1;
                end
            end
        end
        for (int k = 0; k < NUM_WAKEUP; k++) begin
            if (wakeup_valid[k]) begin
                if (wakeup_tag[k] == '0) begin
                    err_d = 1'b1;
                end else if (wakeup_latency[k] == '0 ||
                             wakeup_latency[k] > LAT_W'(MAX_LAT)) begin
                    err_d = 1'b1;
                end else begin
                    if (cnt_q[wakeup_tag[k]] != '0) begin
                        err_d = 1'b1;
                    end
                    cnt_d[wakeup_tag[k]] = wakeup_latency[k];
                end
            end
        end
        // A cancel in the expiry cycle must also undo the expiry's ready.
        if (cancel_valid && cancel_tag != '0) begin
            if (cnt_q[cancel_tag] != '0 || cnt_d[cancel_tag] != '0) begin
                if (cnt_q[cancel_tag] == LAT_W'(1) &&
                    !rdy_q[cancel_tag] && !cmp_hit[cancel_tag]) begin
                    rdy_d[cancel_tag] = 1'b0;
                end
                cnt_d[cancel_tag] = '0;
            end
        end
        rdy_d[0] = 1'b1;
        cnt_d[0] = '0;
    end

    // Source lookups see all same-cycle writes.
    always_comb begin
        dispatch_source_ready = '0;
        for (int i = 0; i < 2*DISPATCH_WIDTH; i++) begin
            dispatch_source_ready[i] = rdy_d[dispatch_source_tag[i]];
        end
    end

    // Table and error state registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rdy_q <= RST_RDY;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            rdy_q <= rdy_d;
            cnt_q <= cnt_d;
            err_q <= err_d | col_err;
        end
    end

    assign DUT_error = err_q;

endmodule

// File: tb/tb_phys_reg_ready_table_sched.sv
// Bench for phys_reg_ready_table_sched: scenario tasks push expected
// reads into a scoreboard and compare them at the falling edge.
module tb_phys_reg_ready_table_sched;

    localparam int TAG_W = 6;
    localparam int LAT_W = 3;

    logic                  CLK = 1'b0;
    logic                  nRST = 1'b1;
    logic                  DUT_error;
    logic [3:0][TAG_W-1:0] dispatch_source_tag;
    logic [3:0]            dispatch_source_ready;
    logic [1:0]            dispatch_dest_write;
    logic [1:0][TAG_W-1:0] dispatch_dest_tag;
    logic [2:0]            complete_valid;
    logic [2:0][TAG_W-1:0] complete_tag;
    logic [1:0]            wakeup_valid;
    logic [1:0][TAG_W-1:0] wakeup_tag;
    logic [1:0][LAT_W-1:0] wakeup_latency;
    logic                  cancel_valid;
    logic [TAG_W-1:0]      cancel_tag;

    phys_reg_ready_table_sched dut (
        .CLK                   (CLK),
        .nRST                  (nRST),
        .DUT_error             (DUT_error),
        .dispatch_source_tag   (dispatch_source_tag),
        .dispatch_source_ready (dispatch_source_ready),
        .dispatch_dest_write   (dispatch_dest_write),
        .dispatch_dest_tag     (dispatch_dest_tag),
        .complete_valid        (complete_valid),
        .complete_tag          (complete_tag),
        .wakeup_valid          (wakeup_valid),
        .wakeup_tag            (wakeup_tag),
        .wakeup_latency        (wakeup_latency),
        .cancel_valid          (cancel_valid),
        .cancel_tag            (cancel_tag)
    );

    always #5 CLK = ~CLK;

    // Scoreboard: source index 0..3 = read port, 4 = DUT_error.
    string sb_name[$];
    int    sb_src[$];
    logic  sb_val[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    task automatic push(input string nm, input int src, input logic v);
        sb_name.push_back(nm);
        sb_src.push_back(src);
        sb_val.push_back(v);
    endtask

    task automatic clr_inputs();
        dispatch_dest_write = '0;
        dispatch_dest_tag   = '0;
        complete_valid      = '0;
        complete_tag        = '0;
        wakeup_valid        = '0;
        wakeup_tag          = '0;
        wakeup_latency      = '0;
        cancel_valid        = 1'b0;
        cancel_tag          = '0;
    endtask

    task automatic test_reset();
        string nm;
        int    s;
        logic  v, obs;
        for (int c = 0; c < 2; c++) begin
            clr_inputs();
            dispatch_source_tag[0] = 6'd5;
            dispatch_source_tag[1] = 6'd31;
            dispatch_source_tag[2] = 6'd32;
            dispatch_source_tag[3] = 6'd63;
            push("rst_t5", 0, 1'b1);
            push("rst_t31", 1, 1'b1);
            push("rst_t32", 2, 1'b0);
            push("rst_t63", 3, 1'b0);
            push("rst_err", 4, 1'b0);
            @(negedge CLK);
            while (sb_src.size() > 0) begin
                nm = sb_name.pop_front();
                s = sb_src.pop_front();
                v = sb_val.pop_front();
                obs = (s == 4) ? DUT_error : dispatch_source_ready[s];
                n_cmp++;
                if (obs !== v) begin
                    n_bad++;
                    $display("FAIL %s: got %b want %b", nm, obs, v);
                end
            end
            @(posedge CLK);
            #1;
            nRST = 1'b1;
        end
    endtask

    task automatic test_dispatch_clear();
        string nm;
        int    s;
        logic  v, obs;
        for (int c = 0; c < 5; c++) begin
            clr_inputs();
            dispatch_source_tag[2] = 6'd40;
            if (c == 0) begin
                dispatch_dest_write[0] = 1'b1;
                dispatch_dest_tag[0]   = 6'd40;
            end
            if (c == 3) begin
                complete_valid[2] = 1'b1;
                complete_tag[2]   = 6'd40;
            end
            push("clr_t40", 2, c >= 3);
            if (c == 1) push("clr_err", 4, 1'b0);
            @(negedge CLK);
            while (sb_src.size() > 0) begin
                nm = sb_name.pop_front();
                s = sb_src.pop_front();
                v = sb_val.pop_front();
                obs = (s == 4) ? DUT_error : dispatch_source_ready[s];
                n_cmp++;
                if (obs !== v) begin
                    n_bad++;
                    $display("FAIL %s c%0d: got %b want %b", nm, c, obs, v);
                end
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_wakeup(input int tag, input int lat, input int ch);
        string nm;
        int    s;
        logic  v, obs;
        for (int c = 0; c <= lat + 2; c++) begin
            clr_inputs();
            dispatch_source_tag[1] = TAG_W'(tag);
            if (c == 0) begin
                dispatch_dest_write[1] = 1'b1;
                dispatch_dest_tag[1]   = TAG_W'(tag);
            end
            if (c == 1) begin
                wakeup_valid[ch]   = 1'b1;
                wakeup_tag[ch]     = TAG_W'(tag);
                wakeup_latency[ch] = LAT_W'(lat);
            end
            push("wk_rd", 1, c >= 1 + lat);
            if (c == 2) push("wk_err", 4, 1'b0);
            @(negedge CLK);
            while (sb_src.size() > 0) begin
                nm = sb_name.pop_front();
                s = sb_src.pop_front();
                v = sb_val.pop_front();
                obs = (s == 4) ? DUT_error : dispatch_source_ready[s];
                n_cmp++;
                if (obs !== v) begin
                    n_bad++;
                    $display("FAIL %s t%0d L%0d c%0d: got %b want %b",
                             nm, tag, lat, c, obs, v);
                end
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_cancel();
        string nm;
        int    s;
        logic  v, obs;
        for (int c = 0; c < 8; c++) begin
            clr_inputs();
            dispatch_source_tag[0] = 6'd50;
            dispatch_source_tag[1] = 6'd51;
            if (c == 0) begin
                wakeup_valid      = 2'b11;
                wakeup_tag[0]     = 6'd50;
                wakeup_tag[1]     = 6'd51;
                wakeup_latency[0] = 3'd2;
                wakeup_latency[1] = 3'd2;
                cancel_valid      = 1'b1;
                cancel_tag        = 6'd51;
            end
            if (c == 2) begin
                cancel_valid = 1'b1;
                cancel_tag   = 6'd50;
            end
            if (c == 6) begin
                complete_valid[0] = 1'b1;
                complete_tag[0]   = 6'd50;
            end
            push("cxl_t50", 0, c >= 6);
            push("cxl_t51", 1, 1'b0);
            if (c == 3) push("cxl_err", 4, 1'b0);
            @(negedge CLK);
            while (sb_src.size() > 0) begin
                nm = sb_name.pop_front();
                s = sb_src.pop_front();
                v = sb_val.pop_front();
                obs = (s == 4) ? DUT_error : dispatch_source_ready[s];
                n_cmp++;
                if (obs !== v) begin
                    n_bad++;
                    $display("FAIL %s c%0d: got %b want %b", nm, c, obs, v);
                end
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_collision();
        string nm;
        int    s;
        logic  v, obs;
        for (int c = 0; c < 6; c++) begin
            clr_inputs();
            dispatch_source_tag[0] = 6'd0;
            dispatch_source_tag[3] = 6'd33;
            if (c == 0) begin
                complete_valid[1:0] = 2'b11;
                complete_tag[0]     = 6'd33;
                complete_tag[1]     = 6'd33;
            end
            if (c == 3) begin
                dispatch_dest_write[1] = 1'b1;
                dispatch_dest_tag[1]   = 6'd0;
            end
            push("col_t33", 3, 1'b1);
            push("col_t0", 0, 1'b1);
            push("col_err", 4, (c == 1) || (c == 4));
            @(negedge CLK);
            while (sb_src.size() > 0) begin
                nm = sb_name.pop_front();
                s = sb_src.pop_front();
                v = sb_val.pop_front();
                obs = (s == 4) ? DUT_error : dispatch_source_ready[s];
                n_cmp++;
                if (obs !== v) begin
                    n_bad++;
                    $display("FAIL %s c%0d: got %b want %b", nm, c, obs, v);
                end
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_bad_latency();
        string nm;
        int    s;
        logic  v, obs;
        for (int c = 0; c < 7; c++) begin
            clr_inputs();
            dispatch_source_tag[0] = 6'd52;
            dispatch_source_tag[1] = 6'd53;
            if (c == 0) begin
                wakeup_valid      = 2'b11;
                wakeup_tag[0]     = 6'd52;
                wakeup_tag[1]     = 6'd53;
                wakeup_latency[0] = 3'd0;
                wakeup_latency[1] = 3'd5;
            end
            push("lat_t52", 0, 1'b0);
            push("lat_t53", 1, 1'b0);
            if (c == 1) push("lat_err1", 4, 1'b1);
            if (c == 2) push("lat_err0", 4, 1'b0);
            @(negedge CLK);
            while (sb_src.size() > 0) begin
                nm = sb_name.pop_front();
                s = sb_src.pop_front();
                v = sb_val.pop_front();
                obs = (s == 4) ? DUT_error : dispatch_source_ready[s];
                n_cmp++;
                if (obs !== v) begin
                    n_bad++;
                    $display("FAIL %s c%0d: got %b want %b", nm, c, obs, v);
                end
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_back_to_back();
        string nm;
        int    s;
        logic  v, obs;
        for (int c = 0; c < 9; c++) begin
            clr_inputs();
            dispatch_source_tag[0] = 6'd55;
            dispatch_source_tag[1] = 6'd56;
            if (c == 0) begin
                dispatch_dest_write[0] = 1'b1;
                dispatch_dest_tag[0]   = 6'd55;
                complete_valid[1]      = 1'b1;
                complete_tag[1]        = 6'd55;
            end
            if (c == 2 || c == 3) begin
                wakeup_valid[0]   = 1'b1;
                wakeup_tag[0]     = 6'd56;
                wakeup_latency[0] = (c == 2) ? 3'd2 : 3'd4;
            end
            push("b2b_t55", 0, 1'b1);
            push("b2b_t56", 1, c >= 7);
            if (c >= 1 && c <= 5)
                push("b2b_err", 4, (c == 1) || (c == 4));
            @(negedge CLK);
            while (sb_src.size() > 0) begin
                nm = sb_name.pop_front();
                s = sb_src.pop_front();
                v = sb_val.pop_front();
                obs = (s == 4) ? DUT_error : dispatch_source_ready[s];
                n_cmp++;
                if (obs !== v) begin
                    n_bad++;
                    $display("FAIL %s c%0d: got %b want %b", nm, c, obs, v);
                end
            end
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset_mid();
        string nm;
        int    s;
        logic  v, obs;
        for (int c = 0; c < 9; c++) begin
            clr_inputs();
            dispatch_source_tag[0] = 6'd60;
            dispatch_source_tag[1] = 6'd33;
            dispatch_source_tag[2] = 6'd5;
            if (c == 0) begin
                wakeup_valid[1]   = 1'b1;
                wakeup_tag[1]     = 6'd60;
                wakeup_latency[1] = 3'd3;
            end
            if (c == 2) nRST = 1'b0;
            if (c == 3) nRST = 1'b1;
            push("rm_t60", 0, 1'b0);
            push("rm_t33", 1, c < 2);
            push("rm_t5", 2, 1'b1);
            if (c >= 2 && c <= 4) push("rm_err", 4, 1'b0);
            @(negedge CLK);
            while (sb_src.size() > 0) begin
                nm = sb_name.pop_front();
                s = sb_src.pop_front();
                v = sb_val.pop_front();
                obs = (s == 4) ? DUT_error : dispatch_source_ready[s];
                n_cmp++;
                if (obs !== v) begin
                    n_bad++;
                    $display("FAIL %s c%0d: got %b want %b", nm, c, obs, v);
                end
            end
            @(posedge CLK);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr_inputs();
        dispatch_source_tag = '0;
        #1;
        nRST = 1'b0;
        test_reset();
        test_dispatch_clear();
        test_wakeup(45, 3, 0);
        test_wakeup(45, 1, 1);
        test_wakeup(47, 4, 0);
        test_cancel();
        test_collision();
        test_bad_latency();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
